// File: rtl/watchdog_supervisor.sv
// watchdog_supervisor: gathers masked firmware heartbeats into watchdog kicks, with grace, revive counting and fault latch
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   arm                 level request to supervise
//   src_mask            per-source participation mask
//   src_heartbeat       per-source one-cycle heartbeat pulses
//   clear_fault         pulse that leaves FAULT and clears revive_count
//   wd_system_reset     watchdog system-reset output being observed
//   wd_heartbeat_start  watchdog start level (MONITOR, KICK, RECOVER)
//   wd_heartbeat_reset  watchdog kick pulse (KICK only)
//   pending             sources already seen in the current round
//   revive_count        saturating count of revive events
//   fault               latched supervision failure
//   state               current state encoding
module watchdog_supervisor #(
  parameter int N_SRC = 4,
  parameter int GRACE_CYCLES = 1000,
  parameter int MAX_REVIVES = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic [N_SRC-1:0] src_mask,
  input  logic [N_SRC-1:0] src_heartbeat,
  input  logic             clear_fault,
  input  logic             wd_system_reset,
  output logic             wd_heartbeat_start,
  output logic             wd_heartbeat_reset,
  output logic [N_SRC-1:0] pending,
  output logic [CNT_W-1:0] revive_count,
  output logic             fault,
  output logic [2:0]       state
);
  localparam int GW = $clog2(GRACE_CYCLES + 1);
  localparam logic [GW-1:0] G_LOAD = GW'(GRACE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_R = CNT_W'(MAX_REVIVES);
  typedef enum logic [2:0] {DISARMED, GRACE, MONITOR, KICK, RECOVER, FAULT} state_t;
  state_t st, st_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [N_SRC-1:0] pend_n, hb;
  logic [CNT_W-1:0] cnt_n;
  logic arm_q, wd_q, wd_d, live, rise, mask_on, done;
  assign state = st;
  assign wd_heartbeat_start = st == MONITOR || st == KICK || st == RECOVER;
  assign wd_heartbeat_reset = st == KICK;
  assign fault = st == FAULT;
  // arm and the watchdog reset are registered once before use, so a level
  // sampled at one edge acts on the state at the following edge
  always_comb begin
    hb = src_heartbeat & src_mask;
    mask_on = |src_mask;
    live = st == MONITOR || st == KICK;
    rise = wd_q & ~wd_d;
    done = mask_on && (pending & src_mask) == src_mask;
    st_n = st;
    gcnt_n = gcnt;
    pend_n = pending;
    cnt_n = revive_count;
    if (st == FAULT) begin
      st_n = clear_fault ? DISARMED : FAULT;
      cnt_n = clear_fault ? '0 : revive_count;
    end else if (!arm_q || (live && !mask_on)) begin
      st_n = DISARMED;
      pend_n = '0;
    end else if (live && rise) begin
      cnt_n = &revive_count ? revive_count : revive_count + 1'b1;
      st_n = cnt_n >= MAX_R ? FAULT : RECOVER;
    end else if (st == DISARMED && mask_on) begin
      st_n = GRACE;
      gcnt_n = G_LOAD;
    end else if (st == GRACE) begin
      st_n = gcnt == '0 ? MONITOR : GRACE;
      gcnt_n = gcnt == '0 ? gcnt : gcnt - 1'b1;
      pend_n = gcnt == '0 ? '0 : pending;
    end else if (st == MONITOR) begin
      // a completed round restarts from the heartbeats arriving on the kick edge
      st_n = done ? KICK : MONITOR;
      pend_n = done ? hb : pending | hb;
    end else if (st == KICK) begin
      st_n = MONITOR;
      pend_n = pending | hb;
    end else if (st == RECOVER && !wd_q) begin
      st_n = GRACE;
      gcnt_n = G_LOAD;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= DISARMED;
      gcnt <= '0;
      pending <= '0;
      revive_count <= '0;
      arm_q <= 1'b0;
      wd_q <= 1'b0;
      wd_d <= 1'b0;
    end else begin
      st <= st_n;
      gcnt <= gcnt_n;
      pending <= pend_n;
      revive_count <= cnt_n;
      arm_q <= arm;
      wd_q <= wd_system_reset;
      wd_d <= wd_q;
    end
  end
endmodule

// File: tb/tb_watchdog_supervisor.sv
// tb_watchdog_supervisor: directed stimulus with a cycle-tagged scoreboard and kick-pulse monitor
module tb_watchdog_supervisor;
  logic clk = 0, rst, arm, clear_fault, wd_system_reset;
  logic [3:0] src_mask, src_heartbeat, pending;
  logic wd_heartbeat_start, wd_heartbeat_reset, fault;
  logic [7:0] revive_count;
  logic [2:0] state;
  int cyc = 0, total = 0, bad = 0;
  int t;
  typedef struct {int cyc; int fld; int exp; string nm;} chk_t;
  chk_t sq[$];
  int kq[$];
  watchdog_supervisor dut (
    .clk(clk), .rst(rst), .arm(arm), .src_mask(src_mask), .src_heartbeat(src_heartbeat),
    .clear_fault(clear_fault), .wd_system_reset(wd_system_reset),
    .wd_heartbeat_start(wd_heartbeat_start), .wd_heartbeat_reset(wd_heartbeat_reset),
    .pending(pending), .revive_count(revive_count), .fault(fault), .state(state)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int get(int f);
    return f == 0 ? int'(state) : f == 1 ? int'(wd_heartbeat_start) : f == 3 ? int'(pending) :
           f == 4 ? int'(revive_count) : int'(fault);
  endfunction
  always @(negedge clk) begin
    for (int i = sq.size() - 1; i >= 0; i--)
      if (sq[i].cyc <= cyc) begin
        total++;
        if (sq[i].cyc != cyc || get(sq[i].fld) != sq[i].exp) begin
          bad++;
          $display("FAIL %s at cyc %0d (due %0d): got %0d want %0d", sq[i].nm, cyc, sq[i].cyc, get(sq[i].fld), sq[i].exp);
        end
        sq.delete(i);
      end
    if (wd_heartbeat_reset) begin
      total++;
      if (kq.size() == 0) begin
        bad++;
        $display("FAIL kick at cyc %0d: got unexpected pulse want none", cyc);
      end else if (kq[0] != cyc) begin
        bad++;
        $display("FAIL kick timing: got cyc %0d want cyc %0d", cyc, kq[0]);
        void'(kq.pop_front());
      end else void'(kq.pop_front());
    end
  end
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic go_to(int c);
    while (cyc < c) tick(1);
  endtask
  task automatic expect_at(int d, int f, int v, string nm);
    sq.push_back('{cyc + d, f, v, nm});
  endtask
  task automatic expect_idle(string nm);
    expect_at(0, 0, 0, {nm, "_state"});
    expect_at(0, 1, 0, {nm, "_start"});
    expect_at(0, 3, 0, {nm, "_pending"});
    expect_at(0, 4, 0, {nm, "_count"});
    expect_at(0, 5, 0, {nm, "_fault"});
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout at cyc %0d", cyc);
    $fatal(1);
  end
  initial begin
    rst = 1; arm = 0; src_mask = 0; src_heartbeat = 0; clear_fault = 0; wd_system_reset = 0;
    tick(3);
    expect_idle("reset");
    tick(1);
    rst = 0;
    tick(1);
    arm = 1; src_mask = 4'b0101; t = cyc;
    expect_at(1001, 0, 1, "grace_end_state");
    expect_at(1001, 1, 0, "grace_end_start");
    expect_at(1002, 0, 2, "monitor_state");
    expect_at(1002, 1, 1, "monitor_start");
    go_to(t + 1002); t = cyc;
    src_heartbeat = 4'b0001; expect_at(1, 3, 1, "pend_src0");
    tick(1);
    src_heartbeat = 4'b1010; expect_at(1, 3, 1, "pend_masked");
    tick(1);
    src_heartbeat = 4'b0100; expect_at(1, 3, 5, "pend_full");
    expect_at(2, 0, 3, "kick_state"); expect_at(2, 3, 0, "kick_pending");
    expect_at(3, 0, 2, "after_kick_state"); expect_at(3, 3, 0, "after_kick_pending");
    kq.push_back(t + 4);
    tick(1);
    src_heartbeat = 0;
    go_to(t + 5);
    src_heartbeat = 4'b0101; kq.push_back(t + 7);
    tick(1);
    src_heartbeat = 0;
    go_to(t + 7);
    src_heartbeat = 4'b0001; expect_at(1, 3, 1, "kick_cycle_hb"); expect_at(1, 0, 2, "kick_to_monitor");
    tick(1);
    src_heartbeat = 4'b1010; expect_at(1, 3, 1, "masked_after_kick");
    tick(1);
    src_heartbeat = 0; t = cyc;
    wd_system_reset = 1;
    expect_at(2, 0, 4, "revive1_state"); expect_at(2, 4, 1, "revive1_count"); expect_at(2, 1, 1, "revive1_start");
    expect_at(10001, 0, 4, "recover_hold_state"); expect_at(10001, 1, 1, "recover_hold_start");
    expect_at(10002, 0, 1, "recover_grace"); expect_at(11002, 0, 2, "recover_monitor");
    expect_at(11002, 3, 0, "recover_pending");
    go_to(t + 10000);
    wd_system_reset = 0;
    go_to(t + 11002); t = cyc;
    src_heartbeat = 4'b0101; wd_system_reset = 1;
    expect_at(1, 0, 2, "race_pre_state");
    expect_at(2, 0, 4, "race_recover"); expect_at(2, 4, 2, "race_count");
    expect_at(3, 0, 1, "race_grace"); expect_at(1003, 0, 2, "race_monitor");
    expect_at(1003, 3, 0, "race_pending");
    tick(1);
    src_heartbeat = 0; wd_system_reset = 0;
    go_to(t + 1003); t = cyc;
    arm = 0; wd_system_reset = 1;
    expect_at(2, 0, 0, "disarm_rev_state"); expect_at(2, 4, 2, "disarm_rev_count"); expect_at(2, 1, 0, "disarm_rev_start");
    tick(1);
    wd_system_reset = 0;
    tick(1);
    arm = 1; expect_at(2, 0, 1, "rearm_grace"); expect_at(1002, 0, 2, "rearm_monitor");
    go_to(t + 1004); t = cyc;
    wd_system_reset = 1;
    expect_at(2, 0, 5, "fault_state"); expect_at(2, 5, 1, "fault_flag");
    expect_at(2, 1, 0, "fault_start"); expect_at(2, 4, 3, "fault_count");
    tick(1);
    wd_system_reset = 0;
    tick(1);
    arm = 0; tick(2); arm = 1; tick(2); arm = 0;
    expect_at(1, 0, 5, "fault_hold_state"); expect_at(1, 5, 1, "fault_hold_flag");
    tick(1);
    clear_fault = 1;
    expect_at(1, 0, 0, "clear_state"); expect_at(1, 4, 0, "clear_count"); expect_at(1, 5, 0, "clear_fault");
    tick(1);
    clear_fault = 0; arm = 1; t = cyc;
    expect_at(2, 0, 1, "post_clear_grace"); expect_at(1002, 0, 2, "post_clear_monitor");
    go_to(t + 1002);
    wd_system_reset = 1;
    expect_at(2, 0, 4, "rst_pre_state"); expect_at(2, 4, 1, "rst_pre_count");
    tick(3);
    rst = 1; wd_system_reset = 0;
    expect_idle("async_rst");
    tick(2);
    rst = 0;
    expect_at(1, 0, 0, "post_rst_disarmed"); expect_at(2, 0, 1, "post_rst_grace");
    tick(5);
    total++;
    if (sq.size() != 0 || kq.size() != 0) begin
      bad++;
      $display("FAIL leftovers: got %0d checks %0d kicks pending want 0", sq.size(), kq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
